// File: rtl/bf_pipe.sv
// Pipelined radix-2 DIT butterfly: oa = a + W*b, ob = a - W*b (conj(W) in inverse mode).
// Three register stages: input capture, rounded complex multiply, add/sub with
// optional halving and saturation. A sticky flag records saturated output beats.
module bf_pipe #(
  parameter int unsigned MULT_WIDTH = 18,
  parameter int unsigned TW_WIDTH   = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    inverse,
  input  logic                    scale,
  input  logic                    in_valid,
  input  logic [2*MULT_WIDTH-1:0] ia,
  input  logic [2*MULT_WIDTH-1:0] ib,
  input  logic [2*TW_WIDTH-1:0]   tw,
  input  logic                    ovf_clr,
  output logic                    out_valid,
  output logic [2*MULT_WIDTH-1:0] oa,
  output logic [2*MULT_WIDTH-1:0] ob,
  output logic                    ovf
);

  localparam int unsigned MW    = MULT_WIDTH;
  localparam int unsigned TWW   = TW_WIDTH;
  // Product-sum width: full-precision product plus one bit for the add/sub.
  localparam int unsigned PW    = MW + TWW + 1;
  // Rounded product keeps one guard bit above the data width.
  localparam int unsigned RW    = MW + 1;
  // Butterfly add/sub width.
  localparam int unsigned AW    = MW + 2;
  localparam int unsigned SHIFT = TWW - 1;

  localparam logic signed [PW-1:0] RND   = PW'(1) <<< (TWW - 2);
  localparam logic signed [AW-1:0] ONE_A = AW'(1);
  localparam logic signed [AW-1:0] MAXV  = {3'b000, {(MW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV  = {3'b111, {(MW-1){1'b0}}};

  // Stage 1 registers
  logic                  s1_valid, s1_inv, s1_scale;
  logic signed [MW-1:0]  s1_ar, s1_ai, s1_br, s1_bi;
  logic signed [TWW-1:0] s1_wr, s1_wi;

  // Stage 2 registers
  logic                  s2_valid, s2_scale;
  logic signed [MW-1:0]  s2_ar, s2_ai;
  logic signed [RW-1:0]  s2_pr, s2_pi;

  // Stage 2 combinational products
  logic signed [PW-1:0]  m_rr, m_ii, m_ri, m_ir, sum_r, sum_i;
  logic signed [RW-1:0]  p_r, p_i;

  // Stage 3 combinational add/sub
  logic signed [AW-1:0]  s_r, s_i, d_r, d_i;
  logic [MW-1:0]         q_sr, q_si, q_dr, q_di;
  logic                  h_sr, h_si, h_dr, h_di;
  logic                  sat_hit;

  // Halve with round-half-up when enabled.
  function automatic logic signed [AW-1:0] scl_fn(input logic signed [AW-1:0] x,
                                                 input logic en);
    logic signed [AW-1:0] t;
    t = x + ONE_A;
    return en ? (t >>> 1) : x;
  endfunction

  // Clamp to the data range; returns {clipped, value}.
  function automatic logic [MW:0] sat_fn(input logic signed [AW-1:0] x);
    logic [MW:0] r;
    if (x > MAXV)      r = {1'b1, 1'b0, {(MW-1){1'b1}}};
    else if (x < MINV) r = {1'b1, 1'b1, {(MW-1){1'b0}}};
    else               r = {1'b0, x[MW-1:0]};
    return r;
  endfunction

  // Stage 1: capture operands, twiddle and per-beat mode bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_inv   <= 1'b0;
      s1_scale <= 1'b0;
      s1_ar    <= '0;
      s1_ai    <= '0;
      s1_br    <= '0;
      s1_bi    <= '0;
      s1_wr    <= '0;
      s1_wi    <= '0;
    end else if (ce) begin
      s1_valid <= in_valid;
      s1_inv   <= inverse;
      s1_scale <= scale;
      s1_ar    <= ia[2*MW-1:MW];
      s1_ai    <= ia[MW-1:0];
      s1_br    <= ib[2*MW-1:MW];
      s1_bi    <= ib[MW-1:0];
      s1_wr    <= tw[2*TWW-1:TWW];
      s1_wi    <= tw[TWW-1:0];
    end
  end

  // Complex multiply b*W (or b*conj(W)), round half-up back to data scale.
  always_comb begin
    m_rr = PW'(s1_br) * PW'(s1_wr);
    m_ii = PW'(s1_bi) * PW'(s1_wi);
    m_ri = PW'(s1_br) * PW'(s1_wi);
    m_ir = PW'(s1_bi) * PW'(s1_wr);
    if (s1_inv) begin
      sum_r = m_rr + m_ii;
      sum_i = m_ir - m_ri;
    end else begin
      sum_r = m_rr - m_ii;
      sum_i = m_ri + m_ir;
    end
    p_r = RW'((sum_r + RND) >>> SHIFT);
    p_i = RW'((sum_i + RND) >>> SHIFT);
  end

  // Stage 2: register rounded product alongside the delayed a operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_scale <= 1'b0;
      s2_ar    <= '0;
      s2_ai    <= '0;
      s2_pr    <= '0;
      s2_pi    <= '0;
    end else if (ce) begin
      s2_valid <= s1_valid;
      s2_scale <= s1_scale;
      s2_ar    <= s1_ar;
      s2_ai    <= s1_ai;
      s2_pr    <= p_r;
      s2_pi    <= p_i;
    end
  end

  // Butterfly add/sub, optional halving, then saturation.
  always_comb begin
    s_r = AW'(s2_ar) + AW'(s2_pr);
    s_i = AW'(s2_ai) + AW'(s2_pi);
    d_r = AW'(s2_ar) - AW'(s2_pr);
    d_i = AW'(s2_ai) - AW'(s2_pi);
    {h_sr, q_sr} = sat_fn(scl_fn(s_r, s2_scale));
    {h_si, q_si} = sat_fn(scl_fn(s_i, s2_scale));
    {h_dr, q_dr} = sat_fn(scl_fn(d_r, s2_scale));
    {h_di, q_di} = sat_fn(scl_fn(d_i, s2_scale));
    sat_hit = h_sr | h_si | h_dr | h_di;
  end

  // Stage 3: output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      oa        <= '0;
      ob        <= '0;
    end else if (ce) begin
      out_valid <= s2_valid;
      oa        <= {q_sr, q_si};
      ob        <= {q_dr, q_di};
    end
  end

  // Sticky overflow: a saturated valid beat takes priority over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (ce && s2_valid && sat_hit) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bf_pipe.sv
// Self-checking bench for bf_pipe: directed cases plus randomized streaming
// against an integer-arithmetic butterfly model with a latency scoreboard.
module tb_bf_pipe;

  localparam int unsigned MW  = 18;
  localparam int unsigned TWW = 18;

  logic          clk = 1'b0;
  logic          rst, ce, inverse, scale, in_valid, ovf_clr;
  logic [35:0]   ia, ib, tw;
  logic          out_valid, ovf;
  logic [35:0]   oa, ob;

  bf_pipe #(.MULT_WIDTH(MW), .TW_WIDTH(TWW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .inverse(inverse), .scale(scale),
    .in_valid(in_valid), .ia(ia), .ib(ib), .tw(tw), .ovf_clr(ovf_clr),
    .out_valid(out_valid), .oa(oa), .ob(ob), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] oa;
    logic [35:0] ob;
    logic        sat;
    int          due;
  } beat_t;

  beat_t       q[$];
  int          errors = 0;
  int          checks = 0;
  int          cnt = 0;
  logic        exp_valid = 1'b0;
  logic        exp_ovf = 1'b0;
  logic [35:0] exp_oa = '0;
  logic [35:0] exp_ob = '0;

  function automatic longint sx(input logic [17:0] v);
    logic signed [17:0] t;
    t = v;
    return longint'(t);
  endfunction

  // Floor division for a positive divisor.
  function automatic longint fdiv(input longint x, input longint d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic longint clamp(input longint x);
    if (x > 131071) return 131071;
    if (x < -131072) return -131072;
    return x;
  endfunction

  // Output component: value after optional halving and clamping, flags clipping.
  function automatic longint finish(input longint x, input logic sc, inout logic hit);
    longint v;
    v = sc ? fdiv(x + 1, 2) : x;
    if (clamp(v) != v) hit = 1'b1;
    return clamp(v);
  endfunction

  // Reference butterfly: complex arithmetic on plain integers.
  task automatic bfly(input logic [35:0] a, b, w, input logic inv, sc,
                      output beat_t r);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    logic   hit;
    ar = sx(a[35:18]); ai = sx(a[17:0]);
    br = sx(b[35:18]); bi = sx(b[17:0]);
    wr = sx(w[35:18]); wi = sx(w[17:0]);
    if (inv) wi = -wi;
    pr = fdiv(br * wr - bi * wi + 65536, 131072);
    pi = fdiv(br * wi + bi * wr + 65536, 131072);
    hit = 1'b0;
    r.oa = {18'(finish(ar + pr, sc, hit)), 18'(finish(ai + pi, sc, hit))};
    r.ob = {18'(finish(ar - pr, sc, hit)), 18'(finish(ai - pi, sc, hit))};
    r.sat = hit;
    r.due = 0;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check.
  task automatic tick();
    beat_t b;
    logic  hit;
    logic  was_rst;
    @(posedge clk);
    was_rst = rst;
    hit = 1'b0;
    if (rst) begin
      q.delete();
      exp_valid = 1'b0;
      exp_ovf = 1'b0;
      exp_oa = '0;
      exp_ob = '0;
    end else begin
      if (ce) begin
        cnt++;
        exp_valid = 1'b0;
        if (q.size() > 0 && q[0].due == cnt) begin
          b = q.pop_front();
          exp_valid = 1'b1;
          exp_oa = b.oa;
          exp_ob = b.ob;
          hit = b.sat;
        end
        if (in_valid) begin
          bfly(ia, ib, tw, inverse, scale, b);
          b.due = cnt + 2;
          q.push_back(b);
        end
      end
      if (hit) exp_ovf = 1'b1;
      else if (ovf_clr) exp_ovf = 1'b0;
    end
    #1;
    chk("out_valid", 36'(out_valid), 36'(exp_valid));
    chk("ovf", 36'(ovf), 36'(exp_ovf));
    if (exp_valid || was_rst) begin
      chk("oa", oa, exp_oa);
      chk("ob", ob, exp_ob);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; ce = 1'b1; ovf_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic beat(input logic [35:0] a, b, w, input logic inv, sc);
    in_valid = 1'b1; ce = 1'b1; ia = a; ib = b; tw = w; inverse = inv; scale = sc;
  endtask

  function automatic logic [17:0] r18();
    case ($urandom_range(0, 5))
      0:       return 18'h20000;
      1:       return 18'h1FFFF;
      2:       return 18'h00000;
      default: return 18'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; ce = 1'b0; inverse = 1'b0; scale = 1'b0; in_valid = 1'b0;
    ovf_clr = 1'b0; ia = '0; ib = '0; tw = '0;
    tick(); tick();
    idle();
    tick();

    // Forward: W = -1
    beat({18'd100, 18'd50}, {18'd30, 18'h3FFEC}, {18'h20000, 18'h0}, 1'b0, 1'b0);
    tick(); idle(); tick(); tick();
    chk("fwd_valid", 36'(out_valid), 36'd1);
    chk("fwd_oa", oa, {18'd70, 18'd70});
    chk("fwd_ob", ob, {18'd130, 18'd30});

    // Inverse: W = -j, conj gives +j
    beat({18'd100, 18'd50}, {18'd30, 18'h3FFEC}, {18'h0, 18'h20000}, 1'b1, 1'b0);
    tick(); idle(); tick(); tick();
    chk("inv_oa", oa, {18'd120, 18'd80});
    chk("inv_ob", ob, {18'd80, 18'd20});

    // Saturation, sticky hold, then clear
    beat({18'h1FFFF, 18'h0}, {18'h1FFFF, 18'h0}, {18'h20000, 18'h0}, 1'b0, 1'b0);
    tick(); idle(); tick(); tick();
    chk("sat_oa", oa, 36'h0);
    chk("sat_ob", ob, {18'h1FFFF, 18'h0});
    chk("sat_ovf", 36'(ovf), 36'd1);
    tick(); tick();
    chk("ovf_hold", 36'(ovf), 36'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 36'(ovf), 36'd0);

    // Scaled: same operands stay in range
    beat({18'h1FFFF, 18'h0}, {18'h1FFFF, 18'h0}, {18'h20000, 18'h0}, 1'b0, 1'b1);
    tick(); idle(); tick(); tick();
    chk("scl_oa", oa, 36'h0);
    chk("scl_ob", ob, {18'h1FFFF, 18'h0});
    chk("scl_ovf", 36'(ovf), 36'd0);

    // Rounding of the halving step
    beat({18'd3, 18'd0}, 36'h0, 36'h0, 1'b0, 1'b1);
    tick(); idle(); tick(); tick();
    chk("rnd_oa", oa, {18'd2, 18'd0});
    chk("rnd_ob", ob, {18'd2, 18'd0});

    // Set beats clear in the same cycle
    beat({18'h1FFFF, 18'h0}, {18'h1FFFF, 18'h0}, {18'h20000, 18'h0}, 1'b0, 1'b0);
    tick(); idle(); tick(); ovf_clr = 1'b1; tick();
    chk("set_wins", 36'(ovf), 36'd1);
    tick(); ovf_clr = 1'b0;
    chk("clr_after", 36'(ovf), 36'd0);

    // Streaming with a two-cycle stall, alternating inverse
    begin
      int k;
      k = 0;
      for (int i = 0; i < 10; i++) begin
        if (i == 4 || i == 5) begin
          ce = 1'b0; in_valid = 1'b1;
          ia = 36'($urandom); ib = 36'($urandom); tw = 36'($urandom);
        end else begin
          beat({r18(), r18()}, {r18(), r18()}, {r18(), r18()}, k[0], 1'($urandom));
          k++;
        end
        tick();
      end
      idle();
      for (int i = 0; i < 4; i++) tick();
    end

    // Reset with two beats in flight, ce low to show reset overrides it
    beat({r18(), r18()}, {r18(), r18()}, {r18(), r18()}, 1'b0, 1'b0);
    tick(); tick();
    in_valid = 1'b0; ce = 1'b0; rst = 1'b1;
    tick();
    chk("rst_valid", 36'(out_valid), 36'd0);
    chk("rst_oa", oa, 36'h0);
    chk("rst_ob", ob, 36'h0);
    idle();
    for (int i = 0; i < 4; i++) tick();

    // Randomized streaming
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      ce       = ($urandom_range(0, 99) < 85);
      in_valid = ($urandom_range(0, 99) < 80);
      ovf_clr  = ($urandom_range(0, 99) < 6);
      inverse  = 1'($urandom);
      scale    = 1'($urandom);
      ia = {r18(), r18()}; ib = {r18(), r18()}; tw = {r18(), r18()};
      tick();
    end
    idle();
    for (int i = 0; i < 5; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
